// File: rtl/ifetch_queue.sv
// ============================================================================
//  Module      : ifetch_queue
//  Description : Instruction-fetch front end. Issues fetches from the PC
//                register, tracks them in an in-order tagged queue for decode
//                and drops stale responses after a redirect flush.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_in,
  output logic             pc_en,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             flush,
  input  logic             deq,
  output logic             inst_valid,
  output logic [31:0]      inst_out,
  output logic [31:0]      inst_pc,
  output logic [CNT_W-1:0] count
);

  localparam int               IDX_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_X   = (CNT_W + 1)'(1);

  // Pointers carry one wrap bit above the entry index.
  logic [CNT_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] head_q, head_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [DEPTH-1:0] filled_q, filled_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic [CNT_W-1:0] count_w;
  logic [CNT_W-1:0] inflight_w;
  logic [CNT_W:0]   drop_sum;
  logic             resp_drop;
  logic             resp_fill;
  logic             do_deq;

  logic [IDX_W-1:0] tail_idx;
  logic [IDX_W-1:0] fill_idx;
  logic [IDX_W-1:0] head_idx;

  assign tail_idx   = tail_q[IDX_W-1:0];
  assign fill_idx   = fill_q[IDX_W-1:0];
  assign head_idx   = head_q[IDX_W-1:0];

  assign count_w    = tail_q - head_q;
  assign inflight_w = tail_q - fill_q;

  // Issue is gated until every response owed to a flushed request has drained.
  assign imem_req   = !reset && !flush && (count_w < DEPTH_C) && (drop_q == '0);
  assign imem_addr  = pc_in;
  assign pc_en      = imem_req && imem_ack;

  assign resp_drop  = imem_rvalid && !flush && (drop_q != '0);
  assign resp_fill  = imem_rvalid && !flush && (drop_q == '0) && (fill_q != tail_q);

  assign inst_valid = (head_q != fill_q);
  assign inst_out   = data_mem[head_idx];
  assign inst_pc    = pc_mem[head_idx];
  assign count      = count_w;

  assign do_deq     = deq && inst_valid && !flush;

  always_comb begin
    tail_d   = tail_q;
    fill_d   = fill_q;
    head_d   = head_q;
    drop_d   = drop_q;
    filled_d = filled_q;
    drop_sum = '0;

    if (flush) begin
      tail_d   = '0;
      fill_d   = '0;
      head_d   = '0;
      filled_d = '0;
      // A response arriving in the flush cycle belongs to a dropped request.
      drop_sum = {1'b0, drop_q} + {1'b0, inflight_w};
      if (imem_rvalid && (drop_sum != '0)) begin
        drop_sum = drop_sum - ONE_X;
      end
      drop_d   = drop_sum[CNT_W-1:0];
    end else begin
      if (pc_en) begin
        tail_d             = tail_q + ONE_C;
        filled_d[tail_idx] = 1'b0;
      end
      if (resp_fill) begin
        fill_d             = fill_q + ONE_C;
        filled_d[fill_idx] = 1'b1;
      end
      if (resp_drop) begin
        drop_d = drop_q - ONE_C;
      end
      if (do_deq) begin
        head_d = head_q + ONE_C;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tail_q   <= '0;
      fill_q   <= '0;
      head_q   <= '0;
      drop_q   <= '0;
      filled_q <= '0;
    end else begin
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      head_q   <= head_d;
      drop_q   <= drop_d;
      filled_q <= filled_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pc_en) begin
      pc_mem[tail_idx] <= pc_in;
    end
    if (resp_fill && !reset) begin
      data_mem[fill_idx] <= imem_rdata;
    end
  end

endmodule

`default_nettype wire
